// File: rtl/int_vector_ctrl_pkg.sv
// Shared definitions for the interrupt vector controller and the constant bank
// that answers its vector reads.
package int_vector_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_VEC,
    ST_SERVICE
  } state_t;

  // Constant-bank indices holding each source's vector.
  localparam int VEC_HWINT  = 1;
  localparam int VEC_SWINT  = 2;
  localparam int VEC_EXCEPT = 3;

  // Bit positions of each source inside the pending/eligible vectors.
  localparam int SRC_HWINT  = 0;
  localparam int SRC_SWINT  = 1;
  localparam int SRC_EXCEPT = 2;

endpackage

// File: rtl/int_vector_ctrl_prio_enc.sv
// Fixed-priority encoder: except > swint > hwint, mapped to constant-bank indices.
module int_prio_enc
  import int_vector_ctrl_pkg::*;
#(
  parameter int SEL_WIDTH = 4
) (
  input  logic [2:0]           eligible,
  output logic                 valid,
  output logic [SEL_WIDTH-1:0] index
);

  always_comb begin
    valid = |eligible;
    index = '0;
    if (eligible[SRC_EXCEPT])
      index = SEL_WIDTH'(VEC_EXCEPT);
    else if (eligible[SRC_SWINT])
      index = SEL_WIDTH'(VEC_SWINT);
    else if (eligible[SRC_HWINT])
      index = SEL_WIDTH'(VEC_HWINT);
  end

endmodule

// File: rtl/int_vector_ctrl.sv
// Interrupt vector controller: latches requests, raises irq, reads the winning
// vector from the constant bank over bus a, and holds it until iret.
module int_vector_ctrl
  import int_vector_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int SEL_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hwint,
  input  logic                 swint,
  input  logic                 except,
  input  logic                 int_en,
  output logic                 irq,
  input  logic                 ack,
  input  logic                 iret,
  output logic                 oe_a,
  output logic [SEL_WIDTH-1:0] sel_a,
  input  logic [WORD_SIZE-1:0] a,
  output logic [WORD_SIZE-1:0] vector,
  output logic                 in_service
);

  state_t               state;
  logic [2:0]           pending;
  logic                 en_q;
  logic [SEL_WIDTH-1:0] frozen_idx;
  logic [2:0]           requests;
  logic [2:0]           eligible;
  logic [2:0]           taken_clr;
  logic                 win_valid;
  logic [SEL_WIDTH-1:0] win_idx;

  // The enable mask is registered alongside the pending bits, so a request
  // pulse and an enable change both reach irq with the same two-cycle latency.
  assign requests = {except, swint, hwint};
  assign eligible = pending & {1'b1, en_q, en_q};

  int_prio_enc #(
    .SEL_WIDTH(SEL_WIDTH)
  ) u_prio_enc (
    .eligible(eligible),
    .valid   (win_valid),
    .index   (win_idx)
  );

  always_comb begin
    taken_clr = '0;
    if (state == ST_VEC) begin
      if (frozen_idx == SEL_WIDTH'(VEC_EXCEPT))
        taken_clr[SRC_EXCEPT] = 1'b1;
      else if (frozen_idx == SEL_WIDTH'(VEC_SWINT))
        taken_clr[SRC_SWINT] = 1'b1;
      else if (frozen_idx == SEL_WIDTH'(VEC_HWINT))
        taken_clr[SRC_HWINT] = 1'b1;
    end
  end

  // A request arriving in the same cycle its bit is cleared wins, so it is
  // never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pending    <= '0;
      en_q       <= 1'b0;
      frozen_idx <= '0;
      vector     <= '0;
      irq        <= 1'b0;
      oe_a       <= 1'b0;
      sel_a      <= '0;
      in_service <= 1'b0;
    end else begin
      pending <= (pending & ~taken_clr) | requests;
      en_q    <= int_en;
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            state <= ST_REQ;
            irq   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (!win_valid) begin
            state <= ST_IDLE;
            irq   <= 1'b0;
          end else if (ack) begin
            state      <= ST_VEC;
            irq        <= 1'b0;
            oe_a       <= 1'b1;
            sel_a      <= win_idx;
            frozen_idx <= win_idx;
            in_service <= 1'b1;
          end
        end
        ST_VEC: begin
          state  <= ST_SERVICE;
          vector <= a;
          oe_a   <= 1'b0;
          sel_a  <= '0;
        end
        ST_SERVICE: begin
          if (iret) begin
            state      <= ST_IDLE;
            in_service <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/int_vector_ctrl.md
INT_VECTOR_CTRL -- requirements
Module: int_vector_ctrl

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, meaning the constant-bus data width.
REQ-002 SHALL have parameter SEL_WIDTH, default 4, meaning the constant-bank select width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port hwint, input, 1, hardware interrupt request pulse.
REQ-006 SHALL have port swint, input, 1, software interrupt request pulse.
REQ-007 SHALL have port except, input, 1, exception request pulse.
REQ-008 SHALL have port int_en, input, 1, interrupt enable mask for hwint/swint only.
REQ-009 SHALL have port irq, output, 1, interrupt pending to the control unit.
REQ-010 SHALL have port ack, input, 1, control-unit acceptance of irq.
REQ-011 SHALL have port iret, input, 1, return-from-interrupt pulse that ends service.
REQ-012 SHALL have port oe_a, output, 1, output enable to the constant bank, port a.
REQ-013 SHALL have port sel_a, output, SEL_WIDTH, constant index to the constant bank, port a.
REQ-014 SHALL have port a, input, WORD_SIZE, shared tri-state bus read back during the vector cycle.
REQ-015 SHALL have port vector, output, WORD_SIZE, latched vector of the interrupt in service.
REQ-016 SHALL have port in_service, output, 1, high from the vector cycle until iret.

Function
REQ-017 SHALL keep one sticky pending bit per source; set on its request pulse, cleared only when that source is taken in VEC.
REQ-018 SHALL resolve same-cycle set and clear of one pending bit in favour of set.
REQ-019 SHALL treat a source as eligible when its pending bit is set, and, for hwint/swint, int_en=1; except is never masked.
REQ-020 SHALL use priority except > swint > hwint, evaluated combinationally from eligible pending bits.
REQ-021 SHALL implement FSM IDLE, REQ, VEC, SERVICE.
REQ-022 IDLE: go to REQ next cycle when any source is eligible.
REQ-023 REQ: irq=1; if ack=1 go to VEC; if no source remains eligible (int_en dropped, no except), return to IDLE with irq=0 and pending bits kept.
REQ-024 REQ: the winning source SHALL be frozen into a registered index on the ack cycle; later higher-priority arrivals stay pending.
REQ-025 VEC: lasts exactly one cycle; oe_a=1, sel_a = frozen index (except=3, swint=2, hwint=1); bus a sampled into vector at the end of the cycle; the taken pending bit cleared; then go to SERVICE.
REQ-026 SERVICE: in_service=1, irq=0, no nesting; iret returns to IDLE; new requests accumulate as pending.
REQ-027 SHALL drive oe_a=0 and sel_a=0 in every state except VEC.
REQ-028 SHALL ignore ack outside REQ and iret outside SERVICE.
REQ-029 Latency: request pulse in cycle N with idle FSM gives irq=1 in cycle N+2; ack in cycle M gives oe_a=1 in cycle M+1 and vector valid in cycle M+2.

Reset
REQ-030 rst=1 SHALL force state IDLE, all pending bits 0, frozen index 0, vector 0, irq 0, oe_a 0, sel_a 0, in_service 0 at the next edge.
REQ-031 rst SHALL take priority over any request, ack, or iret in the same cycle, including mid-VEC or mid-SERVICE.

Structure
REQ-032 A shared package SHALL hold the FSM state enum and the vector index constants VEC_HWINT=1, VEC_SWINT=2, VEC_EXCEPT=3, which the constant bank also uses.
REQ-033 One sub-module, int_prio_enc, SHALL map the three eligible bits to a valid flag and a SEL_WIDTH index.

Verification
REQ-034 Bench SHALL cover: hwint pulse with int_en=1, ack two cycles later -> one-cycle oe_a=1 with sel_a=1, vector=1, in_service=1, and irq=0 after VEC.
REQ-035 Bench SHALL cover: hwint, swint, and except in the same cycle -> services taken in the order 3, 2, 1, each after its iret, with vector=3, 2, 1.
REQ-036 Bench SHALL cover: swint with int_en=0 -> irq stays 0; raising int_en -> irq=1 two cycles later; except with int_en=0 -> irq=1.
REQ-037 Bench SHALL cover: int_en dropped while in REQ with only hwint pending -> IDLE, irq=0, hwint pending retained and re-served after int_en=1.
REQ-038 Bench SHALL cover: hwint during SERVICE -> no irq until iret, then irq=1 two cycles after iret.
REQ-039 Bench SHALL cover: rst asserted in VEC -> next cycle all outputs 0, pending cleared, and no vector latched.
